// File: rtl/sram_burst_ctrl.sv
// ADSC#-initiated single/4-beat burst controller for a pipelined DCD sync-burst SRAM.
// Tracks read latency with a tag pipe and inserts read->write bus turnaround.
module sram_burst_ctrl #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 36,
    parameter int RD_LAT     = 3,
    parameter int BURST_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_burst,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_adsc_,
    output logic              sram_adsp_,
    output logic              sram_adv_,
    output logic              sram_ce_,
    output logic              sram_ce2,
    output logic              sram_ce2_,
    output logic              sram_bwe_,
    output logic              sram_gw_,
    output logic [3:0]        sram_bw_,
    output logic              sram_oe_,
    output logic              sram_mode,
    output logic              sram_zz,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in
);

    typedef enum logic [1:0] {IDLE, RD, WAIT_RD, WR} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [RD_LAT:0]   tag_v_q, tag_l_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [3:0]        wr_be_q;
    logic              wr_burst_q;

    logic [ADDR_W-1:0] addr_d;
    logic              ce_d, adsc_d, adv_d, bwe_d;
    logic [3:0]        bw_d;
    logic              wr_ready_d, req_ready_d;
    logic              push_v, push_l, hold_ld;
    logic              inflight;

    assign inflight   = |tag_v_q;
    assign sram_adsp_ = 1'b1;
    assign sram_ce2   = 1'b1;
    assign sram_ce2_  = 1'b0;
    assign sram_gw_   = 1'b1;
    assign sram_zz    = 1'b0;
    assign sram_mode  = (BURST_MODE != 0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = sram_addr;
        ce_d       = 1'b1;
        adsc_d     = 1'b1;
        adv_d      = 1'b1;
        bwe_d      = 1'b1;
        bw_d       = 4'hF;
        wr_ready_d = 1'b0;
        push_v     = 1'b0;
        push_l     = 1'b0;
        hold_ld    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    hold_ld = req_write;
                    cnt_d   = 2'd0;
                    unique case (1'b1)
                        !req_write: begin
                            ce_d   = 1'b0;
                            adsc_d = 1'b0;
                            addr_d = req_addr;
                            push_v = 1'b1;
                            push_l = !req_burst;
                            if (req_burst) state_d = RD;
                        end
                        req_write && inflight: state_d = WAIT_RD;
                        req_write && !inflight: begin
                            ce_d       = 1'b0;
                            adsc_d     = 1'b0;
                            addr_d     = req_addr;
                            bwe_d      = 1'b0;
                            bw_d       = ~req_be;
                            wr_ready_d = 1'b1;
                            state_d    = WR;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            RD: begin
                adv_d  = 1'b0;
                push_v = 1'b1;
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd2) begin
                    push_l  = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_RD: begin
                // one full cycle of oe_ high before the write address goes out
                if (!inflight && sram_oe_) begin
                    ce_d       = 1'b0;
                    adsc_d     = 1'b0;
                    addr_d     = wr_addr_q;
                    bwe_d      = 1'b0;
                    bw_d       = ~wr_be_q;
                    wr_ready_d = 1'b1;
                    cnt_d      = 2'd0;
                    state_d    = WR;
                end
            end
            WR: begin
                if (wr_burst_q && cnt_q != 2'd3) begin
                    adv_d      = 1'b0;
                    bwe_d      = 1'b0;
                    bw_d       = ~wr_be_q;
                    wr_ready_d = 1'b1;
                    cnt_d      = cnt_q + 2'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            tag_v_q     <= '0;
            tag_l_q     <= '0;
            wr_addr_q   <= '0;
            wr_be_q     <= 4'h0;
            wr_burst_q  <= 1'b0;
            req_ready   <= 1'b0;
            wr_ready    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_last     <= 1'b0;
            rd_data     <= '0;
            sram_addr   <= '0;
            sram_adsc_  <= 1'b1;
            sram_adv_   <= 1'b1;
            sram_ce_    <= 1'b1;
            sram_bwe_   <= 1'b1;
            sram_bw_    <= 4'hF;
            sram_oe_    <= 1'b1;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tag_v_q    <= {tag_v_q[RD_LAT-1:0], push_v};
            tag_l_q    <= {tag_l_q[RD_LAT-1:0], push_l};
            if (hold_ld) begin
                wr_addr_q  <= req_addr;
                wr_be_q    <= req_be;
                wr_burst_q <= req_burst;
            end
            req_ready  <= req_ready_d;
            wr_ready   <= wr_ready_d;
            rd_valid   <= tag_v_q[RD_LAT];
            rd_last    <= tag_l_q[RD_LAT];
            if (tag_v_q[RD_LAT]) rd_data <= sram_dq_in;
            sram_addr  <= addr_d;
            sram_adsc_ <= adsc_d;
            sram_adv_  <= adv_d;
            sram_ce_   <= ce_d;
            sram_bwe_  <= bwe_d;
            sram_bw_   <= bw_d;
            // low whenever the next tag pipe still holds a read
            sram_oe_   <= ~|{tag_v_q[RD_LAT-1:0], push_v};
            sram_dq_oe <= wr_ready;
            if (wr_ready) sram_dq_out <= wr_data;
        end
    end

endmodule
